seven_segment_display_decoder: RTL
==================================

# seven_segment_display_decoder

- Receive-side counterpart of the multiplexed 4-digit seven-segment display driver.
- Samples the time-multiplexed active-low anode/cathode bus and decodes each digit pattern back to BCD.
- Assembles complete 4-digit frames and reports the displayed value in BCD and binary.
- Used as the bomb-timer readback/self-check monitor and as the bench checker for display output.

## Interface
- STABLE_CYCLES, 16: cycles the synchronized anode+segment pair must be unchanged before a digit is sampled (≥2).
- TIMEOUT_CYCLES, 2000000: cycles without any digit sample before the data is declared stale (20 ms).
- clock_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high.
- anode_in  input  4  active-low digit enables; 0111=thousands, 1011=hundreds, 1101=tens, 1110=units.
- segment_in  input  7  active-low cathodes, bit6=a … bit0=g.
- digits_out  output  16  BCD of last good frame, [15:12]=thousands … [3:0]=units.
- value_out  output  14  binary of digits_out (0–9999).
- frame_valid  output  1  one-cycle pulse when digits_out/value_out update.
- pattern_error  output  1  one-cycle pulse when a frame is discarded for an undecodable pattern.
- stale  output  1  level; high when no valid frame has been decoded recently.

## Operation
- **Input synchronization:** anode_in and segment_in pass through 2-flop synchronizers. All logic below uses the synchronized values.
- **Settle FSM:** two states, SETTLE and HOLD.
  - SETTLE: stability counter increments each cycle the synchronized pair equals its previous-cycle value, and clears to 0 on any change.
  - When the counter reaches STABLE_CYCLES-1 and the anode is a valid one-cold code, sample the digit and go to HOLD.
  - HOLD: wait for any change in the pair, then return to SETTLE with the counter at 0.
  - Anode 1111 or multi-low codes: never sampled, not an error; the FSM stays in SETTLE.
- **Digit decode:** patterns decode to 0–9: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9. Any other pattern is invalid.
- **Frame assembly:**
  - A 4-bit capture mask and 4 digit holding registers are maintained.
  - A sample writes its digit register and sets its mask bit.
  - Re-sampling a digit already in the mask overwrites it.
  - An invalid sample sets an internal frame-error flag.
- **Frame completion:** when the mask becomes 1111:
  - If the frame-error flag is clear: load digits_out, load value_out = d3·1000 + d2·100 + d1·10 + d0, pulse frame_valid, clear stale.
  - If the frame-error flag is set: pulse pattern_error; digits_out and value_out hold.
  - In both cases, clear the mask and the frame-error flag.
- **Timeout:** a counter counts cycles since the last sample and clears on every sample. On reaching TIMEOUT_CYCLES: set stale, clear the mask and frame-error flag, and saturate the counter.
- **Simultaneous events:**
  - A sample and a timeout in the same cycle: the sample wins and the timeout is ignored.
  - An invalid sample that completes the mask: pattern_error, never frame_valid.

## Timing
- **Reset values:** digits_out=0, value_out=0, frame_valid=0, pattern_error=0, stale=1. Internally: FSM=SETTLE, all counters=0, mask=0, error flag=0, synchronizers=all-ones.
- **Reset mid-frame:** partial captures are discarded; the next frame needs all four digits again.
- **Sample latency:** a digit is sampled on the edge 2+STABLE_CYCLES cycles after the pair settles at the input pins. At most one sample is taken per dwell.
- **Frame latency:** frame_valid/pattern_error assert on the cycle after the fourth sample. digits_out and value_out change on that same edge and are stable until the next good frame. value_out is registered, with no combinational path from inputs.
- **Dwell requirement:** dwells shorter than 2+STABLE_CYCLES cycles are never sampled. At 100 MHz, the driver's 2.6 ms dwell is sampled once.
- **Stale timing:** stale rises exactly TIMEOUT_CYCLES cycles after the last sample. It falls on the frame_valid edge.

## Test plan
- **Good frame:** drive digits 0,0,4,5 on anodes 0111→1011→1101→1110, dwell 64 cycles each, STABLE_CYCLES=16. Required: one frame_valid pulse, digits_out=16'h0045, value_out=45, stale=0.
- **Maximum value:** drive 9,9,9,9 after the 0045 frame. Required: digits_out=16'h9999, value_out=9999, exactly one frame_valid per 4-digit cycle.
- **Invalid pattern:** drive segment 1111111 on hundreds in an otherwise valid frame. Required: one pattern_error pulse, no frame_valid, outputs keep 0045.
- **Glitch rejection:** change segment_in after 10 stable cycles, then hold 64 cycles. Required: exactly one sample, from the second pattern, and no sample of the first.
- **Timeout:** hold anode=1111 with TIMEOUT_CYCLES=1000. Required: stale=1 exactly 1000 cycles after the last sample and the mask cleared; the next full good frame drops stale on frame_valid.
- **Reset mid-frame:** assert reset after 3 digits are sampled. Required: all outputs at reset values immediately; a following single digit produces no frame_valid; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/seven_segment_display_decoder.sv
// rtl/seven_segment_display_decoder.sv - recovers BCD/binary frames from a multiplexed active-low 7-segment bus
// Each settled anode/segment dwell is sampled once; four distinct digits make a frame.
module seven_segment_display_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  segment_in,
  output logic [15:0] digits_out,
  output logic [13:0] value_out,
  output logic        frame_valid,
  output logic        pattern_error,
  output logic        stale
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  logic [3:0]       anode_s1_q, anode_s2_q, anode_prev_q;
  logic [6:0]       seg_s1_q, seg_s2_q, seg_prev_q;
  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [TW-1:0]    tout_q, tout_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       mask_q, mask_d;
  logic             ferr_q, ferr_d;
  logic [15:0]      digits_q, digits_d;
  logic [13:0]      value_q, value_d;
  logic             fv_q, fv_d, pe_q, pe_d, stale_q, stale_d;

  logic             changed, anode_ok, dec_ok, sample;
  logic [1:0]       pos;
  logic [3:0]       dec_digit;

  assign changed = {anode_s2_q, seg_s2_q} != {anode_prev_q, seg_prev_q};

  always_comb begin
    anode_ok = 1'b1;
    pos      = 2'd0;
    case (anode_s2_q)
      4'b0111: pos = 2'd3;
      4'b1011: pos = 2'd2;
      4'b1101: pos = 2'd1;
      4'b1110: pos = 2'd0;
      default: anode_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'd0;
    case (seg_s2_q)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      default:    dec_ok    = 1'b0;
    endcase
  end

  // Sample on the edge where the stability count would reach STABLE_CYCLES-1.
  assign sample = (state_q == ST_SETTLE) && !changed && (stab_q == STABLE_PRE) && anode_ok;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    if (changed) begin
      stab_d  = '0;
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE) begin
      if (stab_q != STABLE_MAX) stab_d = stab_q + 1'b1;
      if (sample) state_d = ST_HOLD;
    end
  end

  always_comb begin
    digit_d  = digit_q;
    mask_d   = mask_q;
    ferr_d   = ferr_q;
    digits_d = digits_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    pe_d     = 1'b0;
    stale_d  = stale_q;
    tout_d   = tout_q;
    if (sample) begin
      tout_d       = '0;
      digit_d[pos] = dec_ok ? dec_digit : 4'd0;
      mask_d       = mask_q | (4'b0001 << pos);
      ferr_d       = ferr_q | !dec_ok;
      if (mask_d == 4'hF) begin
        if (!ferr_d) begin
          digits_d = digit_d;
          value_d  = 14'(digit_d[3]) * 14'd1000 + 14'(digit_d[2]) * 14'd100
                   + 14'(digit_d[1]) * 14'd10 + 14'(digit_d[0]);
          fv_d     = 1'b1;
          stale_d  = 1'b0;
        end else begin
          pe_d = 1'b1;
        end
        mask_d = '0;
        ferr_d = 1'b0;
      end
    end else begin
      if (tout_q != TIMEOUT_MAX) tout_d = tout_q + 1'b1;
      if (tout_q == TIMEOUT_PRE) begin
        stale_d = 1'b1;
        mask_d  = '0;
        ferr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      anode_s1_q   <= 4'hF;
      anode_s2_q   <= 4'hF;
      anode_prev_q <= 4'hF;
      seg_s1_q     <= 7'h7F;
      seg_s2_q     <= 7'h7F;
      seg_prev_q   <= 7'h7F;
      state_q      <= ST_SETTLE;
      stab_q       <= '0;
      tout_q       <= '0;
      digit_q      <= '0;
      mask_q       <= '0;
      ferr_q       <= 1'b0;
      digits_q     <= '0;
      value_q      <= '0;
      fv_q         <= 1'b0;
      pe_q         <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      anode_s1_q   <= anode_in;
      anode_s2_q   <= anode_s1_q;
      anode_prev_q <= anode_s2_q;
      seg_s1_q     <= segment_in;
      seg_s2_q     <= seg_s1_q;
      seg_prev_q   <= seg_s2_q;
      state_q      <= state_d;
      stab_q       <= stab_d;
      tout_q       <= tout_d;
      digit_q      <= digit_d;
      mask_q       <= mask_d;
      ferr_q       <= ferr_d;
      digits_q     <= digits_d;
      value_q      <= value_d;
      fv_q         <= fv_d;
      pe_q         <= pe_d;
      stale_q      <= stale_d;
    end
  end

  assign digits_out    = digits_q;
  assign value_out     = value_q;
  assign frame_valid   = fv_q;
  assign pattern_error = pe_q;
  assign stale         = stale_q;

endmodule
